// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared types, constants and next-state helper for the LFSR PRNG
package lfsr_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } fsm_state_t;

    localparam int LFSR_MAX_W = 64;
    localparam logic [30:0] LFSR_TAPS_31 = 31'h4800_0000;

    // Operates on a widened vector so one helper serves every WIDTH up to LFSR_MAX_W.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
        input logic [LFSR_MAX_W-1:0] state,
        input logic [LFSR_MAX_W-1:0] taps,
        input int                    width
    );
        logic [LFSR_MAX_W-1:0] mask;
        logic                  fb;
        mask = (LFSR_MAX_W'(1) << width) - LFSR_MAX_W'(1);
        fb   = ^(state & taps);
        return {state[LFSR_MAX_W-2:0], fb} & mask;
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// rtl/lfsr_core.sv - Fibonacci LFSR state register with seed load, zero guard and period mark
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 31,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR_TAPS_31),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step_req,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] state,
    output logic             stepped,
    output logic             lockup,
    output logic             period_mark
);

    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] loaded_q, loaded_d;
    logic             lockup_q, lockup_d;
    logic             mark_q, mark_d;
    logic [WIDTH-1:0] next_step;
    logic [WIDTH-1:0] load_val;

    always_comb begin
        next_step = WIDTH'(lfsr_next(LFSR_MAX_W'(state_q), LFSR_MAX_W'(TAPS), WIDTH));
        load_val  = (seed_in == '0) ? SEED : seed_in;
        state_d   = state_q;
        loaded_d  = loaded_q;
        lockup_d  = lockup_q;
        mark_d    = 1'b0;
        stepped   = 1'b0;
        if (seed_load) begin
            state_d  = load_val;
            loaded_d = load_val;
            if (seed_in == '0) begin
                lockup_d = 1'b1;
            end
        end else if (state_q == '0) begin
            // All-zero state can only come from corruption; recover and flag it.
            state_d  = SEED;
            lockup_d = 1'b1;
        end else if (step_req) begin
            state_d = next_step;
            stepped = 1'b1;
            mark_d  = (next_step == loaded_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q  <= SEED;
            loaded_q <= SEED;
            lockup_q <= 1'b0;
            mark_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            loaded_q <= loaded_d;
            lockup_q <= lockup_d;
            mark_q   <= mark_d;
        end
    end

    assign state       = state_q;
    assign lockup      = lockup_q;
    assign period_mark = mark_q;

endmodule

// File: rtl/lfsr_prng_gen.sv
// rtl/lfsr_prng_gen.sv - LFSR PRNG top: packs serial bits into words behind a valid/ready port
module lfsr_prng_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 31,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR_TAPS_31),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1),
    parameter int               OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             serial_out,
    output logic             lockup,
    output logic             period_mark,
    output logic [WIDTH-1:0] state_out
);

    localparam int           CW       = $clog2(OUT_W + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OUT_W - 1);

    fsm_state_t       fsm_q, fsm_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [OUT_W-1:0] word_q, word_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] word_shift;
    logic             step_req;
    logic             stepped;
    logic [WIDTH-1:0] lfsr_state;

    assign step_req = en && (fsm_q == FILL);

    lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) u_core (
        .clk         (clk),
        .rst_n       (rst_n),
        .step_req    (step_req),
        .seed_load   (seed_load),
        .seed_in     (seed_in),
        .state       (lfsr_state),
        .stepped     (stepped),
        .lockup      (lockup),
        .period_mark (period_mark)
    );

    always_comb begin
        fsm_d       = fsm_q;
        cnt_d       = cnt_q;
        word_d      = word_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        word_shift  = (word_q << 1) | OUT_W'(lfsr_state[WIDTH-1]);
        case (fsm_q)
            FILL: begin
                if (seed_load) begin
                    cnt_d  = '0;
                    word_d = '0;
                end else if (stepped) begin
                    if (cnt_q == CNT_LAST) begin
                        out_data_d  = word_shift;
                        out_valid_d = 1'b1;
                        cnt_d       = '0;
                        word_d      = '0;
                        fsm_d       = HOLD;
                    end else begin
                        cnt_d  = cnt_q + CW'(1);
                        word_d = word_shift;
                    end
                end
            end
            HOLD: begin
                // A seed load here leaves the held word untouched.
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    fsm_d       = FILL;
                end
            end
            default: fsm_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            fsm_q       <= FILL;
            cnt_q       <= '0;
            word_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            cnt_q       <= cnt_d;
            word_q      <= word_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign serial_out = lfsr_state[WIDTH-1];
    assign state_out  = lfsr_state;

endmodule

// File: tb/tb_lfsr_prng_gen.sv
// tb/tb_lfsr_prng_gen.sv - self-checking bench for lfsr_prng_gen against a bit-stream model
module tb_lfsr_prng_gen;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, en, seed_load, out_ready;
    logic [30:0] seed_in;
    logic [7:0]  out_data;
    logic        out_valid, serial_out, lockup, period_mark;
    logic [30:0] state_out;

    logic        en4, seed_load4, out_ready4;
    logic [3:0]  seed_in4;
    logic [0:0]  out_data4;
    logic        out_valid4, serial_out4, lockup4, period_mark4;
    logic [3:0]  state_out4;

    lfsr_prng_gen dut (
        .clk(clk), .rst_n(rst_n), .en(en), .seed_load(seed_load), .seed_in(seed_in),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .serial_out(serial_out), .lockup(lockup), .period_mark(period_mark),
        .state_out(state_out)
    );

    lfsr_prng_gen #(.WIDTH(4), .TAPS(4'b1100), .SEED(4'd1), .OUT_W(1)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en4), .seed_load(seed_load4), .seed_in(seed_in4),
        .out_data(out_data4), .out_valid(out_valid4), .out_ready(out_ready4),
        .serial_out(serial_out4), .lockup(lockup4), .period_mark(period_mark4),
        .state_out(state_out4)
    );

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    logic [30:0] ms;
    logic [7:0]  expw;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Reference: new bit = parity of tapped bits (taps 30 and 27), state doubles and adds it.
    function automatic logic [30:0] ref_next(input logic [30:0] s);
        int ones;
        ones = $countones(s & 31'h4800_0000);
        return 31'((s * 2) + (ones % 2));
    endfunction

    task automatic next_word(output logic [7:0] w);
        w = 8'h00;
        for (int i = 0; i < 8; i++) begin
            w  = 8'((w * 2) + ms[30]);
            ms = ref_next(ms);
        end
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 200) begin
            tick();
            n++;
        end
        chk({tag, "_timeout"}, 64'(out_valid), 64'd1);
    endtask

    task automatic check_word(input string tag);
        next_word(expw);
        chk({tag, "_data"}, 64'(out_data), 64'(expw));
        chk({tag, "_state"}, 64'(state_out), 64'(ms));
    endtask

    initial begin
        int          last;
        logic        checked;
        logic [30:0] rs;
        int          pulses, first_pulse, distinct;
        logic [15:0] seen;

        rst_n = 1'b1; en = 1'b0; seed_load = 1'b0; seed_in = '0; out_ready = 1'b1;
        en4 = 1'b0; seed_load4 = 1'b0; seed_in4 = '0; out_ready4 = 1'b1;
        tick();
        tick();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_state", 64'(state_out), 64'd1);
        chk("rst_lockup", 64'(lockup), 64'd0);
        chk("rst_mark", 64'(period_mark), 64'd0);
        chk("rst_serial", 64'(serial_out), 64'd0);

        // Free-running words with ready held high.
        rst_n = 1'b0; en = 1'b1; ms = 31'd1;
        last = cyc;
        for (int k = 0; k < 4; k++) begin
            wait_valid("run");
            check_word("run");
            chk("run_interval", 64'(cyc - last), (k == 0) ? 64'd8 : 64'd9);
            last = cyc;
            tick();
            chk("run_valid_drop", 64'(out_valid), 64'd0);
        end

        // Backpressure: word and state frozen while ready is low.
        out_ready = 1'b0;
        wait_valid("bp");
        check_word("bp");
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("bp_hold_valid", 64'(out_valid), 64'd1);
            chk("bp_hold_data", 64'(out_data), 64'(expw));
            chk("bp_hold_state", 64'(state_out), 64'(ms));
        end
        out_ready = 1'b1;
        tick();
        chk("bp_release", 64'(out_valid), 64'd0);
        wait_valid("bp_next");
        check_word("bp_next");
        tick();

        // Random en / ready: word stream must be unaffected by stalls.
        checked = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (out_valid) begin
                if (!checked) begin
                    check_word("rnd");
                    checked = 1'b1;
                end else begin
                    chk("rnd_hold", 64'(out_data), 64'(expw));
                end
            end
            en        = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            if (out_valid && out_ready) checked = 1'b0;
            tick();
        end
        en = 1'b1;
        out_ready = 1'b1;
        if (out_valid && !checked) check_word("drain");
        if (out_valid) tick();

        // Zero seed load in the middle of a word.
        wait_valid("pre_zero");
        check_word("pre_zero");
        tick();
        tick(); tick(); tick();
        chk("zero_pre_valid", 64'(out_valid), 64'd0);
        seed_load = 1'b1; seed_in = '0;
        tick();
        seed_load = 1'b0;
        chk("zero_state", 64'(state_out), 64'd1);
        chk("zero_lockup", 64'(lockup), 64'd1);
        chk("zero_valid", 64'(out_valid), 64'd0);
        chk("zero_mark", 64'(period_mark), 64'd0);
        ms = 31'd1;
        last = cyc;
        wait_valid("zero_word");
        chk("zero_interval", 64'(cyc - last), 64'd8);
        check_word("zero_word");
        chk("zero_sticky", 64'(lockup), 64'd1);

        // Seed load with en while holding a word.
        out_ready = 1'b0;
        tick();
        rs = 31'($urandom);
        if (rs == '0) rs = 31'h1234;
        seed_load = 1'b1; seed_in = rs; en = 1'b1;
        tick();
        seed_load = 1'b0;
        chk("hload_valid", 64'(out_valid), 64'd1);
        chk("hload_data", 64'(out_data), 64'(expw));
        chk("hload_state", 64'(state_out), 64'(rs));
        chk("hload_lockup", 64'(lockup), 64'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("hload_nostep", 64'(state_out), 64'(rs));
        end
        ms = rs;
        out_ready = 1'b1;
        tick();
        chk("hload_release", 64'(out_valid), 64'd0);
        for (int k = 0; k < 2; k++) begin
            wait_valid("hload_word");
            check_word("hload_word");
            tick();
        end

        // Reset while holding with ready low.
        out_ready = 1'b0;
        wait_valid("pre_rst");
        check_word("pre_rst");
        tick();
        rst_n = 1'b1;
        en4 = 1'b1;
        tick();
        chk("hrst_valid", 64'(out_valid), 64'd0);
        chk("hrst_state", 64'(state_out), 64'd1);
        chk("hrst_lockup", 64'(lockup), 64'd0);
        chk("hrst_data", 64'(out_data), 64'd0);
        en = 1'b0;
        rst_n = 1'b0;

        // Small 4-bit instance: period 15 steps, two cycles per step at OUT_W=1.
        pulses = 0; first_pulse = 0; last = 0; seen = '0;
        for (int t = 1; t <= 95; t++) begin
            tick();
            seen[state_out4] = 1'b1;
            if (period_mark4) begin
                pulses++;
                if (pulses == 1) first_pulse = t;
                else chk("p4_interval", 64'(t - last), 64'd30);
                last = t;
            end
        end
        distinct = $countones(seen);
        chk("p4_pulses", 64'(pulses), 64'd3);
        chk("p4_first", 64'(first_pulse), 64'd29);
        chk("p4_distinct", 64'(distinct), 64'd15);
        chk("p4_no_zero", 64'(seen[0]), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lfsr_prng_gen.md
Name: lfsr_prng_gen

Overview:
Parametrised pseudo-random generator built on a Fibonacci LFSR of configurable width and tap mask. It packs successive serial output bits into OUT_W-bit words and presents them on a valid/ready interface. It adds seed loading, zero-state lockup protection with a sticky flag, and a period-mark pulse on return to the loaded seed. It is the general-purpose successor to the fixed 31-bit single-bit LFSR on the top-level output pins and feeds uo_out-style pins or on-chip consumers.

Parameters:
WIDTH, 31, LFSR state width (>=3).
TAPS, 31'h4800_0000, feedback mask; bit i set means state[i] is XORed into feedback (default = taps 30,27).
SEED, 1, reset/substitute seed; must be nonzero, WIDTH bits.
OUT_W, 8, output word width (1..WIDTH).

Ports:
clk  in  1  clock
rst_n  in  1  synchronous reset, active-high (despite the name), sampled on posedge clk
en  in  1  allow LFSR to advance
seed_load  in  1  one-cycle request to load seed_in
seed_in  in  WIDTH  seed value
out_data  out  OUT_W  packed word, first-produced bit in MSB
out_valid  out  1  out_data valid
out_ready  in  1  consumer accepts word
serial_out  out  1  current state[WIDTH-1], combinational from state
lockup  out  1  sticky: a zero seed was substituted
period_mark  out  1  one-cycle pulse when state re-equals last loaded seed
state_out  out  WIDTH  current LFSR state

Behaviour:
- Reset (rst_n=1 at posedge): state=SEED, bit counter=0, shift word=0, out_data=0, out_valid=0, lockup=0, period_mark=0, FSM=FILL, loaded_seed=SEED. Reset has priority over everything.
- Step: fb = ^(state & TAPS); state <= {state[WIDTH-2:0], fb}; emitted bit = state[WIDTH-1] before shift, shifted into word LSB (word <= {word[OUT_W-2:0], bit}).
- FSM FILL: a step occurs on each cycle with en=1 and seed_load=0. After the OUT_W-th step, out_data <= completed word, out_valid <= 1 next edge, counter <= 0, FSM -> HOLD.
- FSM HOLD: LFSR stalls; out_data/out_valid stable. On out_valid & out_ready: out_valid <= 0, FSM -> FILL. No step occurs on the handshake cycle. Minimum word period is OUT_W+1 cycles.
- en=0: no step, no counter change; a pending HOLD handshake still completes.
- seed_load (priority below reset, above step):
  - state <= (seed_in==0) ? SEED : seed_in; loaded_seed takes the same value.
  - lockup <= 1 if seed_in==0; lockup clears only on reset.
  - In FILL: partial word and counter are discarded (cleared).
  - In HOLD: held word, out_valid and FSM are preserved.
- Zero-state guard: if state is ever 0 (not reachable with a nonzero mask except via corruption), the next cycle forces state=SEED and sets lockup.
- period_mark: registered; asserted for one cycle after a step whose new state equals loaded_seed. Never asserted on the load cycle itself.
- No output changes combinationally with out_ready.

Decomposition:
- Package lfsr_pkg: FSM state enum {FILL, HOLD}; function lfsr_next(state, taps) returning the next state; default tap constant for 31 bits.
- One sub-module, lfsr_core: state register, step, seed load, zero guard, period_mark.
- lfsr_prng_gen holds the packer FSM and the handshake.

Test Plan:
- Reset, then en=1, out_ready=1, defaults → first four words 0x00, 0x00, 0x00, 0x02; each out_valid for exactly 1 cycle, 9 cycles apart.
- out_ready=0 for 20 cycles after first out_valid → out_data stays 0x00, state_out frozen at 0x0000_0100; after ready, the next word is still 0x00.
- seed_load with seed_in=0 mid-FILL → state_out=1, lockup=1 and sticky; partial word discarded; next word 0x00 after 8 steps.
- WIDTH=4, TAPS=4'b1100, OUT_W=1, seed 1, ready=1 → period_mark pulses every 15 steps (30 cycles); 15 distinct nonzero states seen.
- seed_load=1 and en=1 in the same cycle while in HOLD → held word unchanged, no step, state=seed_in.
- rst_n asserted during HOLD with out_ready=0 → next cycle out_valid=0, state=SEED, lockup=0.
